// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file defaults and the legal read-port range.
//   DATA_W_DEF / ADDR_W_DEF : default register width and address width (depth = 2**ADDR_W)
//   NRD_DEF                 : default number of read ports
//   NRD_MIN / NRD_MAX       : supported read-port count range, checked by nrd_ok()
package cpu_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int NRD_DEF    = 2;
   localparam int NRD_MIN    = 1;
   localparam int NRD_MAX    = 4;
   function automatic bit nrd_ok(input int n);
      return n >= NRD_MIN && n <= NRD_MAX;
   endfunction
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one read port with same-cycle write bypass and scoreboard masking.
//   addr_i            : read address
//   stored_i, busy_i  : stored entry and its scoreboard bit for addr_i
//   weN_i/waN_i/wdN_i : qualified write lanes (lane 1 has priority)
//   data_o, busy_o    : bypassed read data and effective busy status
module rf_read_port
   import cpu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] stored_i,
   input  logic              busy_i,
   input  logic              we0_i,
   input  logic [ADDR_W-1:0] wa0_i,
   input  logic [DATA_W-1:0] wd0_i,
   input  logic              we1_i,
   input  logic [ADDR_W-1:0] wa1_i,
   input  logic [DATA_W-1:0] wd1_i,
   output logic [DATA_W-1:0] data_o,
   output logic              busy_o
);
   logic hit0, hit1;
   assign hit0   = we0_i && wa0_i == addr_i;
   assign hit1   = we1_i && wa1_i == addr_i;
   assign data_o = addr_i == '0 ? '0 : hit1 ? wd1_i : hit0 ? wd0_i : stored_i;
   // a write landing this cycle retires the producer, so the reader sees it ready
   assign busy_o = busy_i && !(hit0 || hit1);
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two write lanes, bypassed reads and a busy scoreboard.
//   rd_addr/rd_data/rd_busy : NRD flattened read ports (port i in slice i)
//   we0/wa0/wd0, we1/wa1/wd1: write lanes, lane 1 wins on the same address
//   set_en/set_addr         : mark a destination pending at issue
//   dbg_addr/dbg_data       : stored value only, no bypass
//   busy_vec                : raw scoreboard bits
module regfile_mp
   import cpu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NRD    = NRD_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NRD*ADDR_W-1:0] rd_addr,
   output logic [NRD*DATA_W-1:0] rd_data,
   output logic [NRD-1:0]        rd_busy,
   input  logic                  we0,
   input  logic [ADDR_W-1:0]     wa0,
   input  logic [DATA_W-1:0]     wd0,
   input  logic                  we1,
   input  logic [ADDR_W-1:0]     wa1,
   input  logic [DATA_W-1:0]     wd1,
   input  logic                  set_en,
   input  logic [ADDR_W-1:0]     set_addr,
   input  logic [ADDR_W-1:0]     dbg_addr,
   output logic [DATA_W-1:0]     dbg_data,
   output logic [2**ADDR_W-1:0]  busy_vec
);
   localparam int DEPTH = 2**ADDR_W;
   if (!nrd_ok(NRD)) begin : g_nrd_bad
      $error("regfile_mp: NRD out of range");
   end
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic              we0_v, we1_v, set_v;
   // gating writes with rst_n keeps the bypass paths quiet while reset is held
   assign we0_v = we0 && rst_n && wa0 != '0;
   assign we1_v = we1 && rst_n && wa1 != '0;
   assign set_v = set_en && set_addr != '0;
   // lane 1 is applied after lane 0 and the set after both clears, giving the required priorities
   always_comb begin
      mem_d  = mem_q;
      busy_d = busy_q;
      if (we0_v) begin
         mem_d[wa0]  = wd0;
         busy_d[wa0] = 1'b0;
      end
      if (we1_v) begin
         mem_d[wa1]  = wd1;
         busy_d[wa1] = 1'b0;
      end
      if (set_v) busy_d[set_addr] = 1'b1;
      mem_d[0]  = '0;
      busy_d[0] = 1'b0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q  <= '{default: '0};
         busy_q <= '0;
      end else begin
         mem_q  <= mem_d;
         busy_q <= busy_d;
      end
   end
   assign dbg_data = mem_q[dbg_addr];
   assign busy_vec = busy_q;
   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [ADDR_W-1:0] a;
      assign a = rd_addr[i*ADDR_W +: ADDR_W];
      rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp (
         .addr_i  (a),
         .stored_i(mem_q[a]),
         .busy_i  (busy_q[a]),
         .we0_i   (we0_v),
         .wa0_i   (wa0),
         .wd0_i   (wd0),
         .we1_i   (we1_v),
         .wa1_i   (wa1),
         .wd1_i   (wd1),
         .data_o  (rd_data[i*DATA_W +: DATA_W]),
         .busy_o  (rd_busy[i])
      );
   end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp (32x32, two read ports).
module tb_regfile_mp;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [9:0]  rd_addr = '0;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic        we0 = 1'b0, we1 = 1'b0, set_en = 1'b0;
   logic [4:0]  wa0 = '0, wa1 = '0, set_addr = '0, dbg_addr = '0;
   logic [31:0] wd0 = '0, wd1 = '0, dbg_data, busy_vec;
   int          tests = 0, fails = 0;
   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2)) dut (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
      .set_en(set_en), .set_addr(set_addr), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
      .busy_vec(busy_vec)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      we0 = 1'b0; we1 = 1'b0; set_en = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
   initial begin
      #2;
      chk("rst_busy_vec", busy_vec, 0);
      chk("rst_rd_data", rd_data, 0);
      we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hDEAD; rd_addr = {5'd0, 5'd3}; dbg_addr = 5'd3;
      set_en = 1'b1; set_addr = 5'd4;
      #1;
      chk("rst_no_bypass", rd_data[31:0], 0);
      tick();
      chk("rst_set_discard", busy_vec, 0);
      chk("rst_wr_discard", dbg_data, 0);
      idle();
      #3 rst_n = 1'b1;
      tick();
      chk("post_rst_x3", dbg_data, 0);
      we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h1234;
      tick();
      idle();
      #1;
      chk("x3_rd0", rd_data[31:0], 32'h1234);
      chk("x3_dbg", dbg_data, 32'h1234);
      we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hAAAA;
      we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h5555;
      rd_addr = {5'd5, 5'd3}; dbg_addr = 5'd5;
      #1;
      chk("x5_bypass_rd1", rd_data[63:32], 32'h5555);
      chk("x5_dbg_no_bypass", dbg_data, 0);
      tick();
      idle();
      #1;
      chk("x5_stored", dbg_data, 32'h5555);
      chk("x5_rd1", rd_data[63:32], 32'h5555);
      we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF; set_en = 1'b1; set_addr = 5'd0;
      rd_addr = {5'd5, 5'd0}; dbg_addr = 5'd0;
      #1;
      chk("x0_rd_bypass", rd_data[31:0], 0);
      tick();
      idle();
      #1;
      chk("x0_dbg", dbg_data, 0);
      chk("x0_busy", busy_vec[0], 0);
      set_en = 1'b1; set_addr = 5'd7;
      tick();
      idle();
      rd_addr = {5'd5, 5'd7};
      #1;
      chk("x7_busy_before", rd_busy, 2'b01);
      chk("x7_busy_vec", busy_vec[7], 1);
      we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h77;
      #1;
      chk("x7_busy_masked", rd_busy, 0);
      chk("x7_bypass", rd_data[31:0], 32'h77);
      tick();
      idle();
      dbg_addr = 5'd7;
      #1;
      chk("x7_busy_cleared", busy_vec[7], 0);
      chk("x7_stored", dbg_data, 32'h77);
      set_en = 1'b1; set_addr = 5'd8;
      tick();
      idle();
      rd_addr = {5'd8, 5'd5};
      we1 = 1'b1; wa1 = 5'd8; wd1 = 32'h88;
      #1;
      chk("x8_lane1_mask", rd_busy, 0);
      chk("x8_lane1_bypass", rd_data[63:32], 32'h88);
      tick();
      idle();
      chk("x8_lane1_clear", busy_vec[8], 0);
      set_en = 1'b1; set_addr = 5'd9; we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h9;
      tick();
      idle();
      dbg_addr = 5'd9;
      #1;
      chk("x9_set_wins", busy_vec[9], 1);
      chk("x9_stored", dbg_data, 32'h9);
      we0 = 1'b1; wa0 = 5'd10; wd0 = 32'hA0; we1 = 1'b1; wa1 = 5'd11; wd1 = 32'hB1;
      tick();
      idle();
      rd_addr = {5'd11, 5'd10};
      #1;
      chk("dual_lane", rd_data, {32'hB1, 32'hA0});
      set_en = 1'b1; set_addr = 5'd7;
      tick();
      idle();
      rd_addr = {5'd7, 5'd3}; dbg_addr = 5'd3;
      #1;
      chk("pre_rst_rd0", rd_data[31:0], 32'h1234);
      chk("pre_rst_busy", rd_busy, 2'b10);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_rd", rd_data, 0);
      chk("async_rst_busy", rd_busy, 0);
      chk("async_rst_vec", busy_vec, 0);
      chk("async_rst_dbg", dbg_data, 0);
      we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hDEAD; set_en = 1'b1; set_addr = 5'd9;
      tick();
      chk("mid_rst_vec", busy_vec, 0);
      chk("mid_rst_rd", rd_data[31:0], 0);
      idle();
      #2 rst_n = 1'b1;
      tick();
      chk("lost_x3", dbg_data, 0);
      chk("lost_busy", busy_vec, 0);
      we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h42;
      tick();
      idle();
      #1;
      chk("first_wr_after_rst", dbg_data, 32'h42);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
